// File: rtl/ame_pkg.sv
// Shared definitions for the AME normal-matrix builder: FSM states, matrix
// geometry and the first-row helper used by both affine modes.
package ame_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      ACC,
      DONE
   } ame_nmb_state_t;

   localparam int AME_ROWS = 6;
   localparam int AME_COLS = 7;

   localparam logic [2:0] AME_LAST_ROW = 3'd5;

   // The 4-parameter model only carries c2..c5, so its row walk starts at 2.
   function automatic logic [2:0] ame_first_row(input logic mode6);
      return mode6 ? 3'd0 : 3'd2;
   endfunction

endpackage

// File: rtl/ame_row_mac.sv
// Row product generator: for the selected row k, forms ck*c0..ck*c5 and ck*r
// as signed products sign-extended to the accumulator width.
module ame_row_mac
   import ame_pkg::*;
#(
   parameter int COMP_DATA_BITS = 64,
   parameter int SAMP_DATA_BITS = 24
) (
   input  logic [2:0]                                row_i,
   input  logic [AME_ROWS-1:0][SAMP_DATA_BITS-1:0]   coef_i,
   input  logic [SAMP_DATA_BITS-1:0]                 resi_i,
   output logic [AME_COLS-1:0][COMP_DATA_BITS-1:0]   prod_o
);

   localparam int PW = 2 * SAMP_DATA_BITS;

   logic signed [SAMP_DATA_BITS-1:0] ck;
   logic signed [PW-1:0]             ck_ext;
   logic signed [PW-1:0]             opnd [AME_COLS];
   logic signed [PW-1:0]             raw  [AME_COLS];

   always_comb begin
      ck = '0;
      for (int i = 0; i < AME_ROWS; i++) begin
         if (row_i == 3'(i)) begin
            ck = coef_i[i];
         end
      end
   end

   // Column 6 of the augmented matrix pairs the row coefficient with the residual.
   always_comb begin
      ck_ext = PW'(ck);
      for (int j = 0; j < AME_ROWS; j++) begin
         opnd[j] = PW'($signed(coef_i[j]));
      end
      opnd[AME_COLS-1] = PW'($signed(resi_i));
      for (int j = 0; j < AME_COLS; j++) begin
         raw[j]    = ck_ext * opnd[j];
         prod_o[j] = COMP_DATA_BITS'(raw[j]);
      end
   end

endmodule

// File: rtl/ame_normal_matrix_builder.sv
// Accumulates the symmetric normal matrix A = sum(c*c^T) and vector B = sum(c*r)
// one row per cycle, presenting [A|B] to the downstream equation solver.
module ame_normal_matrix_builder
   import ame_pkg::*;
#(
   parameter int COMP_DATA_BITS = 64,
   parameter int SAMP_DATA_BITS = 24
) (
   input  logic                                                   clk_i,
   input  logic                                                   rst_n_i,
   input  logic                                                   comp_init_i,
   output logic                                                   comp_done_o,
   input  logic                                                   affine_param6_i,
   input  logic                                                   samp_valid_i,
   output logic                                                   samp_ready_o,
   input  logic                                                   samp_last_i,
   input  logic [AME_ROWS-1:0][SAMP_DATA_BITS-1:0]                samp_coef_i,
   input  logic [SAMP_DATA_BITS-1:0]                              samp_resi_i,
   output logic [AME_ROWS-1:0][AME_COLS-1:0][COMP_DATA_BITS-1:0]  comp_data_o
);

   ame_nmb_state_t state_q, state_d;

   logic [AME_ROWS-1:0][AME_COLS-1:0][COMP_DATA_BITS-1:0] mat_q, mat_d;
   logic [AME_ROWS-1:0][SAMP_DATA_BITS-1:0]               coef_q, coef_d;
   logic [SAMP_DATA_BITS-1:0]                             resi_q, resi_d;
   logic                                                  last_q, last_d;
   logic                                                  mode6_q, mode6_d;
   logic                                                  done_q, done_d;
   logic [2:0]                                            row_q, row_d;

   logic [AME_COLS-1:0][COMP_DATA_BITS-1:0]               prod;

   ame_row_mac #(
      .COMP_DATA_BITS (COMP_DATA_BITS),
      .SAMP_DATA_BITS (SAMP_DATA_BITS)
   ) u_row_mac (
      .row_i  (row_q),
      .coef_i (coef_q),
      .resi_i (resi_q),
      .prod_o (prod)
   );

   // Init has priority over everything, so an aborted sample never writes a row.
   always_comb begin
      state_d = state_q;
      mat_d   = mat_q;
      coef_d  = coef_q;
      resi_d  = resi_q;
      last_d  = last_q;
      mode6_d = mode6_q;
      done_d  = 1'b0;
      row_d   = row_q;

      if (comp_init_i) begin
         state_d = RECV;
         mat_d   = '0;
         mode6_d = affine_param6_i;
      end else begin
         case (state_q)
            IDLE: begin
            end
            RECV: begin
               if (samp_valid_i) begin
                  coef_d  = samp_coef_i;
                  resi_d  = samp_resi_i;
                  last_d  = samp_last_i;
                  row_d   = ame_first_row(mode6_q);
                  state_d = ACC;
               end
            end
            ACC: begin
               // Upper-triangle update of row k mirrored into column k keeps A symmetric.
               for (int k = 0; k < AME_ROWS; k++) begin
                  if (row_q == 3'(k)) begin
                     for (int j = k; j < AME_ROWS; j++) begin
                        mat_d[k][j] = mat_q[k][j] + prod[j];
                        mat_d[j][k] = mat_q[k][j] + prod[j];
                     end
                     mat_d[k][AME_COLS-1] = mat_q[k][AME_COLS-1] + prod[AME_COLS-1];
                  end
               end
               if (row_q == AME_LAST_ROW) begin
                  state_d = last_q ? DONE : RECV;
               end else begin
                  row_d = row_q + 3'd1;
               end
            end
            DONE: begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         mat_q   <= '0;
         coef_q  <= '0;
         resi_q  <= '0;
         last_q  <= 1'b0;
         mode6_q <= 1'b0;
         done_q  <= 1'b0;
         row_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         mat_q   <= mat_d;
         coef_q  <= coef_d;
         resi_q  <= resi_d;
         last_q  <= last_d;
         mode6_q <= mode6_d;
         done_q  <= done_d;
         row_q   <= row_d;
      end
   end

   assign samp_ready_o = (state_q == RECV);
   assign comp_done_o  = done_q;
   assign comp_data_o  = mat_q;

endmodule

// File: tb/tb_ame_normal_matrix_builder.sv
// Self-checking bench for ame_normal_matrix_builder: a sample-level reference
// model predicts ready/done timing and the accumulated [A|B] matrix.
module tb_ame_normal_matrix_builder;

   localparam int CB = 64;
   localparam int SB = 24;

   logic                         clk       = 1'b0;
   logic                         rst_n     = 1'b1;
   logic                         comp_init = 1'b0;
   logic                         affine    = 1'b0;
   logic                         valid     = 1'b0;
   logic                         last      = 1'b0;
   logic [5:0][SB-1:0]           coef      = '0;
   logic [SB-1:0]                resi      = '0;
   logic                         done;
   logic                         ready;
   logic [5:0][6:0][CB-1:0]      data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state: expected matrix and sample-level sequencing.
   longint em [6][7];
   bit     m_mode6, m_recv, m_last, m_pend, m_done;
   int     m_cnt;

   ame_normal_matrix_builder #(
      .COMP_DATA_BITS (CB),
      .SAMP_DATA_BITS (SB)
   ) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .comp_init_i     (comp_init),
      .comp_done_o     (done),
      .affine_param6_i (affine),
      .samp_valid_i    (valid),
      .samp_ready_o    (ready),
      .samp_last_i     (last),
      .samp_coef_i     (coef),
      .samp_resi_i     (resi),
      .comp_data_o     (data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic model_clear_matrix();
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 7; j++)
            em[i][j] = 0;
   endtask

   // A whole sample is folded in at acceptance; the matrix is only compared
   // while no sample is in flight, which is when its value is defined.
   task automatic model_accumulate();
      longint ci, cj, r;
      r = longint'($signed(resi));
      for (int i = 0; i < 6; i++) begin
         if (m_mode6 || i >= 2) begin
            ci = longint'($signed(coef[i]));
            for (int j = 0; j < 6; j++) begin
               if (m_mode6 || j >= 2) begin
                  cj = longint'($signed(coef[j]));
                  em[i][j] += ci * cj;
               end
            end
            em[i][6] += ci * r;
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_clear_matrix();
         m_mode6 = 0; m_recv = 0; m_last = 0; m_pend = 0; m_done = 0; m_cnt = 0;
      end else begin
         m_done = 0;
         if (comp_init) begin
            model_clear_matrix();
            m_mode6 = affine;
            m_recv  = 1;
            m_cnt   = 0;
            m_pend  = 0;
         end else if (m_pend) begin
            m_pend = 0;
            m_done = 1;
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               if (m_last) m_pend = 1;
               else        m_recv = 1;
            end
         end else if (m_recv && valid) begin
            model_accumulate();
            m_recv = 0;
            m_last = last;
            m_cnt  = m_mode6 ? 6 : 4;
         end
      end
   end

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, $signed(act), $signed(exp));
      end
   endtask

   task automatic check_matrix(input string name);
      bit bad;
      bad = 0;
      checks++;
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 7; j++) begin
            if (!bad && data[i][j] !== 64'(em[i][j])) begin
               bad = 1;
               errors++;
               $display("[TB] FAIL %s [%0d][%0d] cycle %0d: got %0d expected %0d",
                        name, i, j, cyc, $signed(data[i][j]), em[i][j]);
            end
         end
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s cycle %0d: timed out waiting on DUT", name, cyc);
   endtask

   always @(negedge clk) begin
      check_bit("ready", ready, m_recv);
      check_bit("done", done, m_done);
      if (m_cnt == 0) check_matrix("matrix");
   end

   function automatic logic [5:0][SB-1:0] rand_coef();
      logic [5:0][SB-1:0] c;
      for (int i = 0; i < 6; i++) c[i] = SB'($urandom);
      return c;
   endfunction

   task automatic do_init(input logic mode6);
      comp_init = 1'b1;
      affine    = mode6;
      @(negedge clk);
      comp_init = 1'b0;
      affine    = 1'($urandom);
   endtask

   task automatic send_sample(input logic [5:0][SB-1:0] c, input logic [SB-1:0] r,
                              input logic l, output int acc_edge);
      int guard;
      guard = 0;
      valid = 1'b1;
      coef  = c;
      resi  = r;
      last  = l;
      while (!ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) timeout_fail("accept");
      acc_edge = cyc + 1;
      @(negedge clk);
      valid  = 1'b0;
      coef   = rand_coef();
      resi   = SB'($urandom);
      last   = 1'($urandom);
      affine = 1'($urandom);
   endtask

   task automatic wait_done(input int acc_edge, input int lat, input string name);
      int guard;
      guard = 0;
      while (!done && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) timeout_fail(name);
      else check_val(name, 64'(cyc - acc_edge), 64'(lat));
   endtask

   initial begin
      logic [5:0][SB-1:0] c;
      int acc, accepts, dones, prev, k, nsamp;
      bit pend, mode;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_bit("reset ready", ready, 1'b0);
      check_bit("reset done", done, 1'b0);
      check_val("reset data", data[3][6], 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] 6-param single sample");
      do_init(1'b1);
      for (int i = 0; i < 6; i++) c[i] = SB'(i + 1);
      send_sample(c, SB'(10), 1'b1, acc);
      wait_done(acc, 7, "latency6");
      check_val("A23 dut", data[2][3], 64'd12);
      check_val("A23 model", 64'(em[2][3]), 64'd12);
      check_val("A55 dut", data[5][5], 64'd36);
      check_val("A10 dut", data[1][0], 64'd2);
      check_val("B5 dut", data[5][6], 64'd60);
      check_val("B0 model", 64'(em[0][6]), 64'd10);
      repeat (3) @(negedge clk);

      $display("[TB] 4-param two samples");
      do_init(1'b0);
      c = rand_coef();
      c[2] = SB'(1); c[3] = SB'(-1); c[4] = SB'(2); c[5] = SB'(0);
      send_sample(c, SB'(-3), 1'b0, acc);
      c[0] = SB'($urandom); c[1] = SB'($urandom);
      send_sample(c, SB'(-3), 1'b1, acc);
      wait_done(acc, 5, "latency4");
      check_val("A22", data[2][2], 64'd2);
      check_val("A23", data[2][3], -64'sd2);
      check_val("A32", data[3][2], -64'sd2);
      check_val("A44", data[4][4], 64'd8);
      check_val("B4", data[4][6], -64'sd12);
      check_val("B4 model", 64'(em[4][6]), -64'sd12);
      check_val("row0", data[0][6], 64'd0);
      check_val("row1", data[1][3], 64'd0);
      check_val("col0", data[4][0], 64'd0);
      repeat (2) @(negedge clk);

      $display("[TB] continuous valid");
      do_init(1'b1);
      valid = 1'b1; coef = rand_coef(); resi = SB'($urandom); last = 1'b0;
      k = 0; pend = 0; accepts = 0; dones = 0; prev = -1;
      for (int n = 0; n < 40; n++) begin
         if (pend) begin
            pend = 0;
            k++;
            coef = rand_coef();
            resi = SB'($urandom);
            last = (k == 2);
         end
         if (ready) begin
            accepts++;
            if (prev >= 0) check_val("ready period", 64'(cyc - prev), 64'd7);
            prev = cyc;
            pend = 1;
         end
         if (done) dones++;
         @(negedge clk);
      end
      valid = 1'b0;
      check_val("accepts", 64'(accepts), 64'd3);
      check_val("dones", 64'(dones), 64'd1);

      $display("[TB] init during ACC");
      do_init(1'b1);
      send_sample(rand_coef(), SB'($urandom), 1'b0, acc);
      repeat (3) @(negedge clk);
      comp_init = 1'b1; valid = 1'b1;
      @(negedge clk);
      comp_init = 1'b0; valid = 1'b0;
      check_bit("abort ready", ready, 1'b1);
      check_bit("abort done", done, 1'b0);
      check_val("abort A00", data[0][0], 64'd0);
      check_val("abort A33", data[3][3], 64'd0);
      comp_init = 1'b1; valid = 1'b1;
      @(negedge clk);
      comp_init = 1'b0; valid = 1'b0;
      check_bit("init beats valid", ready, 1'b1);
      repeat (2) @(negedge clk);

      $display("[TB] extreme operands");
      do_init(1'b1);
      c = rand_coef();
      c[0] = 24'h800000; c[1] = 24'h800000;
      send_sample(c, 24'h7FFFFF, 1'b1, acc);
      wait_done(acc, 7, "latency extreme");
      check_val("A01 extreme", data[0][1], 64'h0000_4000_0000_0000);
      check_val("B0 extreme", data[0][6], 64'hFFFF_C000_0080_0000);
      check_val("B0 model", 64'(em[0][6]), 64'hFFFF_C000_0080_0000);

      $display("[TB] reset during ACC");
      do_init(1'b1);
      send_sample(rand_coef(), SB'($urandom), 1'b1, acc);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_bit("async ready", ready, 1'b0);
      check_bit("async done", done, 1'b0);
      check_val("async A00", data[0][0], 64'd0);
      check_matrix("async matrix");
      repeat (2) @(negedge clk);
      valid = 1'b1;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_bit("idle ignores valid", ready, 1'b0);
      valid = 1'b0;

      $display("[TB] randomized blocks");
      for (int b = 0; b < 8; b++) begin
         mode  = 1'($urandom);
         do_init(mode);
         nsamp = 1 + int'($urandom_range(3));
         for (int s = 0; s < nsamp; s++) begin
            repeat ($urandom_range(2)) @(negedge clk);
            send_sample(rand_coef(), SB'($urandom), (s == nsamp - 1), acc);
         end
         wait_done(acc, mode ? 7 : 5, "latency random");
         repeat ($urandom_range(3)) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/ame_normal_matrix_builder.md
AME_NORMAL_MATRIX_BUILDER -- requirements
Module: ame_normal_matrix_builder

Interface
REQ-001 SHALL have parameter COMP_DATA_BITS, default 64, accumulator and output element width.
REQ-002 SHALL have parameter SAMP_DATA_BITS, default 24, signed sample coefficient and residual width.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port comp_init_i, input, 1, clears the matrix and starts a new accumulation.
REQ-006 SHALL have port comp_done_o, output, 1, one-cycle pulse when the matrix is complete.
REQ-007 SHALL have port affine_param6_i, input, 1, 1 = 6-parameter mode, 0 = 4-parameter mode; sampled at comp_init_i.
REQ-008 SHALL have port samp_valid_i, input, 1, sample valid.
REQ-009 SHALL have port samp_ready_o, output, 1, sample ready.
REQ-010 SHALL have port samp_last_i, input, 1, marks the final sample of a block; qualified by valid.
REQ-011 SHALL have port samp_coef_i, input, [5:0][SAMP_DATA_BITS-1:0], signed coefficients c0..c5.
REQ-012 SHALL have port samp_resi_i, input, SAMP_DATA_BITS, signed residual r.
REQ-013 SHALL have port comp_data_o, output, [5:0][6:0][COMP_DATA_BITS-1:0], augmented matrix; row i is A[i][0..5], column 6 is B[i]; it feeds the equation solver's comp_data_i directly.

Function
REQ-014 SHALL accumulate A[i][j] += ci*cj and B[i] += ci*r over all accepted samples, with products sign-extended to COMP_DATA_BITS.
REQ-015 SHALL wrap accumulation modulo 2^COMP_DATA_BITS and SHALL raise no overflow flag.
REQ-016 SHALL use states IDLE, RECV, ACC and DONE.
REQ-017 SHALL move from any state to RECV on comp_init_i, zeroing all 42 elements and latching affine_param6_i.
REQ-018 SHALL drive samp_ready_o = 1 only in RECV; a sample is accepted on an edge with valid&ready, capturing c, r and last, and the FSM enters ACC.
REQ-019 SHALL, in ACC, process one row k per cycle: rows 0..5 in 6-param mode (6 cycles) and rows 2..5 in 4-param mode (4 cycles).
REQ-020 SHALL, for row k, write A[k][j] and the mirror A[j][k] for j>=k, plus B[k]; the result SHALL be symmetric.
REQ-021 SHALL, in 4-param mode, use c2..c5 only and SHALL leave rows 0..1 and columns 0..1 at zero.
REQ-022 SHALL, after the final row, return to RECV if last=0, or enter DONE if last=1.
REQ-023 SHALL assert comp_done_o for exactly one cycle in DONE and then go to IDLE.
REQ-024 SHALL make comp_data_o final on the cycle comp_done_o is high and hold it until the next comp_init_i.
REQ-025 SHALL give a latency from the accepting edge of the last sample to comp_done_o high of 7 cycles (6-param) or 5 cycles (4-param).
REQ-026 SHALL give a throughput of one sample per 7 cycles (6-param) or 5 cycles (4-param).
REQ-027 SHALL ignore samp_valid_i in IDLE, ACC and DONE.
REQ-028 SHALL, when comp_init_i and samp_valid_i are high together, let init win and accept no sample on that edge.
REQ-029 SHALL, on comp_init_i mid-ACC, abort the current sample and clear the matrix with no partial write.
REQ-030 SHALL ignore affine_param6_i changes outside comp_init_i.

Reset
REQ-031 SHALL asynchronously force state IDLE, comp_done_o=0, samp_ready_o=0, comp_data_o all zero and the captured sample registers to zero.
REQ-032 SHALL take its first action after reset release on the next rising edge of clk_i.

Structure
REQ-033 SHALL place state enum ame_nmb_state_t, AME_ROWS=6 and AME_COLS=7 in shared package ame_pkg.
REQ-034 SHALL instantiate sub-module ame_row_mac: 7 signed multipliers that form ck*c0..c5 and ck*r, sign-extended, for a selected row k.

Verification
REQ-035 SHALL cover 6-param, one sample c={1,2,3,4,5,6}, r=10, last=1 -> A[i][j]=(i+1)(j+1), B[i]=10(i+1), comp_done_o 7 cycles after acceptance.
REQ-036 SHALL cover 4-param, two samples c2..c5={1,-1,2,0}, r=-3 each -> A[2][2]=2, A[2][3]=-2, A[4][4]=8, B[4]=-12, rows 0..1 zero, done 5 cycles after the second acceptance.
REQ-037 SHALL cover valid held high continuously -> ready pulses exactly once per 7 cycles; 3 samples give 3 accepts and 1 done.
REQ-038 SHALL cover comp_init_i at ACC row 3 -> all outputs read zero next cycle, ready=1, no done.
REQ-039 SHALL cover c0=c1=-2^23, r=2^23-1, 6-param -> A[0][1]=2^46 and B[0]=-2^46+2^23 in 64-bit two's complement.
REQ-040 SHALL cover rst_n_i low during ACC -> asynchronous clear of all outputs and state IDLE.
